// File: rtl/sc_fifo_pkg.sv
// Shared constants and elaboration helpers for the single-clock FIFO.
package sc_fifo_pkg;

   localparam string SHOWAHEAD_ON  = "ON";
   localparam string SHOWAHEAD_OFF = "OFF";

   // usedw must hold DEPTH itself, so it needs one bit more than a pointer.
   function automatic int usedw_width(input int aw);
      return aw + 1;
   endfunction

   function automatic bit thr_legal(input int thr, input int aw);
      return (thr >= 1) && (thr <= (1 << aw));
   endfunction

endpackage

// File: rtl/sc_fifo_buf_if.sv
// Producer/consumer bus of sc_fifo_buf; ovf_o/udf_o exist only with SC_FIFO_ERR_FLAGS_EN.
interface sc_fifo_buf_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 3
);
   logic [DWIDTH-1:0] data_i;
   logic              wrreq_i;
   logic              rdreq_i;
   logic [DWIDTH-1:0] q_o;
   logic              empty_o;
   logic              full_o;
   logic [AWIDTH:0]   usedw_o;
   logic              almost_full_o;
   logic              almost_empty_o;
`ifdef SC_FIFO_ERR_FLAGS_EN
   logic              ovf_o;
   logic              udf_o;

   modport slave  (input  data_i, wrreq_i, rdreq_i,
                   output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o, ovf_o, udf_o);
   modport master (output data_i, wrreq_i, rdreq_i,
                   input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o, ovf_o, udf_o);
`else
   modport slave  (input  data_i, wrreq_i, rdreq_i,
                   output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o);
   modport master (output data_i, wrreq_i, rdreq_i,
                   input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o);
`endif
endinterface

// File: rtl/sc_fifo_ram.sv
// Simple dual-port RAM, one clock, registered read; maps onto a single M10K.
module sc_fifo_ram #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 3
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AWIDTH-1:0] waddr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AWIDTH-1:0] raddr_i,
   output logic [DWIDTH-1:0] rdata_o
);
   (* ramstyle = "M10K, no_rw_check" *) logic [DWIDTH-1:0] mem_q [2**AWIDTH];
   logic [DWIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sc_fifo_buf.sv
// Single-clock FIFO: pointers, fill counter, registered flags, showahead bypass.
// Optional sticky ovf_o/udf_o via `define SC_FIFO_ERR_FLAGS_EN.
module sc_fifo_buf
   import sc_fifo_pkg::*;
#(
   parameter int    DWIDTH             = 8,
   parameter int    AWIDTH             = 3,
   parameter string SHOWAHEAD          = "OFF",
   parameter int    ALMOST_FULL_VALUE  = 6,
   parameter int    ALMOST_EMPTY_VALUE = 2
) (
   input  logic         clk_i,
   input  logic         srst_i,
   sc_fifo_buf_if.slave bus
);
   localparam int DEPTH = 2**AWIDTH;
   localparam int UW    = usedw_width(AWIDTH);
   localparam bit SA_ON = (SHOWAHEAD == SHOWAHEAD_ON);

   if (!thr_legal(ALMOST_FULL_VALUE, AWIDTH) || !thr_legal(ALMOST_EMPTY_VALUE, AWIDTH) ||
       (SHOWAHEAD != SHOWAHEAD_ON && SHOWAHEAD != SHOWAHEAD_OFF)) begin : g_bad_param
      $error("sc_fifo_buf: illegal parameter value");
   end

   logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [UW-1:0]     cnt_q, cnt_d;
   logic              empty_q, full_q, afull_q, aempty_q;
   logic              wr_ok, rd_ok, ram_we, ram_re;
   logic [DWIDTH-1:0] ram_rdata;

   assign wr_ok  = bus.wrreq_i && !full_q;
   assign rd_ok  = bus.rdreq_i && !empty_q;
   assign ram_we = wr_ok && !srst_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (srst_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   // Flags come from the next-state count so they line up with usedw_o.
   always_ff @(posedge clk_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (srst_i) begin
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         empty_q  <= (cnt_d == '0);
         full_q   <= (cnt_d == UW'(DEPTH));
         afull_q  <= (cnt_d >= UW'(ALMOST_FULL_VALUE));
         aempty_q <= (cnt_d <  UW'(ALMOST_EMPTY_VALUE));
      end
   end

   if (SA_ON) begin : g_show
      // RAM prefetches the next head every cycle; a same-cycle write to that
      // address is forwarded from a side register instead.
      logic              byp_q;
      logic [DWIDTH-1:0] byp_data_q;

      assign ram_re = 1'b1;
      always_ff @(posedge clk_i) begin
         byp_q      <= ram_we && (wr_ptr_q == rd_ptr_d);
         byp_data_q <= bus.data_i;
      end
      assign bus.q_o = empty_q ? '0 : (byp_q ? byp_data_q : ram_rdata);
   end else begin : g_norm
      // RAM output register has no reset; mask it until the first read.
      logic zero_q;

      assign ram_re = rd_ok && !srst_i;
      always_ff @(posedge clk_i) begin
         if (srst_i)     zero_q <= 1'b1;
         else if (rd_ok) zero_q <= 1'b0;
      end
      assign bus.q_o = zero_q ? '0 : ram_rdata;
   end

   sc_fifo_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.data_i),
      .re_i    (ram_re),
      .raddr_i (SA_ON ? rd_ptr_d : rd_ptr_q),
      .rdata_o (ram_rdata)
   );

`ifdef SC_FIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (bus.wrreq_i && full_q);
         udf_q <= udf_q | (bus.rdreq_i && empty_q);
      end
   end
   assign bus.ovf_o = ovf_q;
   assign bus.udf_o = udf_q;
`endif

   assign bus.usedw_o        = cnt_q;
   assign bus.empty_o        = empty_q;
   assign bus.full_o         = full_q;
   assign bus.almost_full_o  = afull_q;
   assign bus.almost_empty_o = aempty_q;
endmodule

// File: tb/tb_sc_fifo_buf.sv
// Directed vector bench for sc_fifo_buf in normal and showahead modes.
module tb_sc_fifo_buf;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   tests = 0, fails = 0;

   always #5 clk = ~clk;

   sc_fifo_buf_if #(.DWIDTH(8), .AWIDTH(3)) ba ();
   sc_fifo_buf_if #(.DWIDTH(8), .AWIDTH(3)) bb ();

   sc_fifo_buf #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("OFF"),
                 .ALMOST_FULL_VALUE(6), .ALMOST_EMPTY_VALUE(2))
      dut_a (.clk_i(clk), .srst_i(rst_a), .bus(ba));
   sc_fifo_buf #(.DWIDTH(8), .AWIDTH(3), .SHOWAHEAD("ON"),
                 .ALMOST_FULL_VALUE(6), .ALMOST_EMPTY_VALUE(2))
      dut_b (.clk_i(clk), .srst_i(rst_b), .bus(bb));

   typedef struct {
      logic       rst, wr, rd;
      logic [7:0] d;
      logic [7:0] q;
      int         uw;
      logic       ovf, udf;
   } vec_t;
   vec_t vt[$];

   task automatic add(input logic rst, wr, rd, input logic [7:0] d, q,
                      input int uw, input logic ovf, udf);
      vec_t v;
      v.rst = rst; v.wr = wr; v.rd = rd; v.d = d; v.q = q; v.uw = uw; v.ovf = ovf; v.udf = udf;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      ba.wrreq_i = 0; ba.rdreq_i = 0; ba.data_i = 0;
      bb.wrreq_i = 0; bb.rdreq_i = 0; bb.data_i = 0;

      add(1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
      for (int i = 1; i <= 8; i++) add(0, 1, 0, 8'(i), 8'h00, i, 0, 0);
      add(0, 1, 0, 8'hFF, 8'h00, 8, 1, 0);
      for (int k = 1; k <= 8; k++) add(0, 0, 1, 8'h00, 8'(k), 8 - k, 1, 0);
      add(0, 0, 1, 8'h00, 8'h08, 0, 1, 1);
      for (int i = 0; i < 4; i++)  add(0, 1, 0, 8'(8'h10 + i), 8'h08, i + 1, 1, 1);
      for (int i = 0; i < 20; i++) add(0, 1, 1, 8'(8'h14 + i), 8'(8'h10 + i), 4, 1, 1);
      for (int i = 0; i < 4; i++)  add(0, 1, 0, 8'(8'h28 + i), 8'h23, 5 + i, 1, 1);
      add(0, 1, 1, 8'h99, 8'h24, 7, 1, 1);
      for (int i = 0; i < 7; i++)  add(0, 0, 1, 8'h00, 8'(8'h25 + i), 6 - i, 1, 1);
      for (int i = 0; i < 5; i++)  add(0, 1, 0, 8'(8'h50 + i), 8'h2B, i + 1, 1, 1);
      add(1, 1, 1, 8'h77, 8'h00, 0, 0, 0);
      add(0, 1, 0, 8'h60, 8'h00, 1, 0, 0);
      add(0, 0, 1, 8'h00, 8'h60, 0, 0, 0);

      foreach (vt[n]) begin
         rst_a = vt[n].rst; ba.wrreq_i = vt[n].wr; ba.rdreq_i = vt[n].rd; ba.data_i = vt[n].d;
         @(posedge clk); #1;
         chk($sformatf("v%0d.usedw", n), int'(ba.usedw_o), vt[n].uw);
         chk($sformatf("v%0d.empty", n), int'(ba.empty_o), int'(vt[n].uw == 0));
         chk($sformatf("v%0d.full", n),  int'(ba.full_o),  int'(vt[n].uw == 8));
         chk($sformatf("v%0d.afull", n), int'(ba.almost_full_o),  int'(vt[n].uw >= 6));
         chk($sformatf("v%0d.aempty", n), int'(ba.almost_empty_o), int'(vt[n].uw < 2));
         chk($sformatf("v%0d.q", n), int'(ba.q_o), int'(vt[n].q));
`ifdef SC_FIFO_ERR_FLAGS_EN
         chk($sformatf("v%0d.ovf", n), int'(ba.ovf_o), int'(vt[n].ovf));
         chk($sformatf("v%0d.udf", n), int'(ba.udf_o), int'(vt[n].udf));
`endif
      end
      rst_a = 1'b0; ba.wrreq_i = 0; ba.rdreq_i = 0;

      // Showahead: head visible with empty_o falling, bypass on write-into-head.
      @(posedge clk); #1;
      chk("sa.rst_empty", int'(bb.empty_o), 1);
      chk("sa.rst_q", int'(bb.q_o), 0);
      rst_b = 1'b0;
      bb.wrreq_i = 1; bb.data_i = 8'hA5;
      @(posedge clk); #1;
      chk("sa.w1_empty", int'(bb.empty_o), 0);
      chk("sa.w1_q", int'(bb.q_o), 8'hA5);
      bb.data_i = 8'h11;
      @(posedge clk); #1;
      chk("sa.w2_q", int'(bb.q_o), 8'hA5);
      chk("sa.w2_usedw", int'(bb.usedw_o), 2);
      bb.rdreq_i = 1; bb.data_i = 8'h22;
      @(posedge clk); #1;
      chk("sa.rw_q", int'(bb.q_o), 8'h11);
      chk("sa.rw_usedw", int'(bb.usedw_o), 2);
      bb.wrreq_i = 0;
      @(posedge clk); #1;
      chk("sa.r_q", int'(bb.q_o), 8'h22);
      chk("sa.r_usedw", int'(bb.usedw_o), 1);
      bb.wrreq_i = 1; bb.data_i = 8'h33;
      @(posedge clk); #1;
      chk("sa.byp_q", int'(bb.q_o), 8'h33);
      chk("sa.byp_usedw", int'(bb.usedw_o), 1);
      bb.wrreq_i = 0;
      @(posedge clk); #1;
      chk("sa.last_empty", int'(bb.empty_o), 1);
      chk("sa.last_aempty", int'(bb.almost_empty_o), 1);
      bb.rdreq_i = 0;
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
